// File: rtl/gf180_ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of one gf180 128x8 SRAM macro.
// Optional post-reset clear sweep is enabled by defining GF180_RAM_ARB_CLEAR_EN.
module gf180_ram_arbiter #(
   parameter int                ADDR_W      = 7,
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [DATA_W-1:0] a_wmask,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [DATA_W-1:0] b_wmask,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              busy,
   output logic              ram_cen,
   output logic              ram_gwen,
   output logic [DATA_W-1:0] ram_wen,
   output logic [ADDR_W-1:0] ram_a,
   output logic [DATA_W-1:0] ram_d,
   input  logic [DATA_W-1:0] ram_q
);

   logic              w_busy;
   logic [ADDR_W-1:0] w_sweep_addr;
   logic              w_grant_a;
   logic              w_grant_b;
   logic              r_last_b;
   logic              r_a_rvalid;
   logic              r_b_rvalid;

`ifdef GF180_RAM_ARB_CLEAR_EN
   logic              r_sweep;
   logic [ADDR_W-1:0] r_sweep_addr;

   // Clear sweep: armed by reset, writes every address once after release
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sweep      <= 1'b1;
         r_sweep_addr <= {ADDR_W{1'b0}};
      end else if (r_sweep) begin
         r_sweep_addr <= r_sweep_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
         r_sweep      <= ~(&r_sweep_addr);
      end else begin
         r_sweep      <= 1'b0;
         r_sweep_addr <= r_sweep_addr;
      end
   end

   assign w_busy       = r_sweep & ~RST;
   assign w_sweep_addr = r_sweep_addr;
`else
   assign w_busy       = 1'b0;
   assign w_sweep_addr = {ADDR_W{1'b0}};
`endif

   // Round-robin grant: on a tie the port not served last wins
   always_comb begin
      w_grant_a = a_valid & ~w_busy & ~RST & (~b_valid | r_last_b);
      w_grant_b = b_valid & ~w_busy & ~RST & (~a_valid | ~r_last_b);
   end

   // Macro pins follow the sweep or the granted request in the same cycle
   always_comb begin
      ram_cen  = 1'b1;
      ram_gwen = 1'b1;
      ram_wen  = {DATA_W{1'b1}};
      ram_a    = {ADDR_W{1'b0}};
      ram_d    = {DATA_W{1'b0}};
      if (w_busy) begin
         ram_cen  = 1'b0;
         ram_gwen = 1'b0;
         ram_wen  = {DATA_W{1'b0}};
         ram_a    = w_sweep_addr;
         ram_d    = CLEAR_VALUE;
      end else if (w_grant_a) begin
         ram_cen  = 1'b0;
         ram_gwen = ~a_we;
         ram_wen  = a_we ? ~a_wmask : {DATA_W{1'b1}};
         ram_a    = a_addr;
         ram_d    = a_we ? a_wdata : {DATA_W{1'b0}};
      end else if (w_grant_b) begin
         ram_cen  = 1'b0;
         ram_gwen = ~b_we;
         ram_wen  = b_we ? ~b_wmask : {DATA_W{1'b1}};
         ram_a    = b_addr;
         ram_d    = b_we ? b_wdata : {DATA_W{1'b0}};
      end else begin
         ram_cen  = 1'b1;
      end
   end

   // Pointer and read-response valids; reset favours A and drops in-flight reads
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_last_b   <= 1'b1;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
      end else begin
         if (w_grant_a) begin
            r_last_b <= 1'b0;
         end else if (w_grant_b) begin
            r_last_b <= 1'b1;
         end else begin
            r_last_b <= r_last_b;
         end
         r_a_rvalid <= w_grant_a & ~a_we;
         r_b_rvalid <= w_grant_b & ~b_we;
      end
   end

   assign a_ready  = w_grant_a;
   assign b_ready  = w_grant_b;
   assign a_rvalid = r_a_rvalid;
   assign b_rvalid = r_b_rvalid;
   assign a_rdata  = r_a_rvalid ? ram_q : {DATA_W{1'b0}};
   assign b_rdata  = r_b_rvalid ? ram_q : {DATA_W{1'b0}};
   assign busy     = w_busy;

endmodule

// File: tb/tb_gf180_ram_arbiter.sv
// Self-checking bench for gf180_ram_arbiter: directed scenarios plus randomized traffic
// compared against a memory/fairness reference model; includes a behavioural SRAM macro.
`timescale 1ns/1ps
module tb_gf180_ram_arbiter;

   localparam logic [7:0] CLR = 8'h00;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       a_valid, a_we, b_valid, b_we;
   logic [6:0] a_addr, b_addr;
   logic [7:0] a_wdata, a_wmask, b_wdata, b_wmask;
   logic       a_ready, a_rvalid, b_ready, b_rvalid, busy;
   logic [7:0] a_rdata, b_rdata;
   logic       ram_cen, ram_gwen;
   logic [7:0] ram_wen, ram_d;
   logic [7:0] ram_q = 8'h00;
   logic [6:0] ram_a;
   logic [24:0] pins;

   int total = 0;
   int bad   = 0;
   logic [7:0] sram      [128];
   logic [7:0] model_mem [128];
   bit         model_last_b;
   bit         sram_init = 1'b1;

   assign pins = {ram_cen, ram_gwen, ram_wen, ram_a, ram_d};

   gf180_ram_arbiter dut (
      .CLK(CLK), .RST(RST),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_wmask(a_wmask), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_wmask(b_wmask), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .busy(busy), .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
      .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] init_pattern(input int i);
      return 8'((i * 37) + 8'h5A);
   endfunction

   // Behavioural macro: captures pins on the rising edge, Q updates on reads only
   always @(posedge CLK) begin
      if (sram_init) begin
         for (int i = 0; i < 128; i++) sram[i] <= init_pattern(i);
      end else if (!ram_cen) begin
         if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
         else           ram_q <= sram[ram_a];
      end
   end

   function automatic logic [24:0] idle_pins();
      return {1'b1, 1'b1, 8'hFF, 7'h00, 8'h00};
   endfunction
   function automatic logic [24:0] rd_pins(input logic [6:0] ad);
      return {1'b0, 1'b1, 8'hFF, ad, 8'h00};
   endfunction
   function automatic logic [24:0] wr_pins(input logic [6:0] ad, input logic [7:0] d, input logic [7:0] m);
      return {1'b0, 1'b0, ~m, ad, d};
   endfunction

   task automatic drive_idle();
      a_valid = 1'b0; a_we = 1'b0; a_addr = 7'h00; a_wdata = 8'h00; a_wmask = 8'h00;
      b_valid = 1'b0; b_we = 1'b0; b_addr = 7'h00; b_wdata = 8'h00; b_wmask = 8'h00;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      drive_idle();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      model_last_b = 1'b1;
`ifdef GF180_RAM_ARB_CLEAR_EN
      begin
         int n = 0;
         while (busy !== 1'b0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
         end
         total++;
         if (busy !== 1'b0) begin bad++; $display("FAIL sweep_timeout busy=%b required=0", busy); end
         for (int i = 0; i < 128; i++) model_mem[i] = CLR;
      end
`endif
   endtask

   task automatic test_reset();
      RST = 1'b1;
      a_valid = 1'b1; a_we = 1'b1; a_addr = 7'h12; a_wdata = 8'h3C; a_wmask = 8'hFF;
      b_valid = 1'b1; b_we = 1'b0; b_addr = 7'h05; b_wdata = 8'h00; b_wmask = 8'h00;
      @(posedge CLK); #1 sram_init = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      total++; if ({a_ready, b_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b required=00", {a_ready, b_ready}); end
      total++; if (pins !== idle_pins()) begin bad++; $display("FAIL reset_pins got=%h required=%h", pins, idle_pins()); end
      total++; if ({a_rvalid, b_rvalid, busy} !== 3'b000) begin bad++; $display("FAIL reset_rvalid_busy got=%b required=000", {a_rvalid, b_rvalid, busy}); end
      total++; if ({a_rdata, b_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h required=0000", {a_rdata, b_rdata}); end
      @(posedge CLK); #1;
      do_reset();
   endtask

   task automatic test_write_read();
      a_valid = 1'b1; a_we = 1'b1; a_addr = 7'h05; a_wdata = 8'hA5; a_wmask = 8'hFF;
      @(negedge CLK);
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b required=1", a_ready); end
      total++; if (pins !== wr_pins(7'h05, 8'hA5, 8'hFF)) begin bad++; $display("FAIL wr_pins got=%h required=%h", pins, wr_pins(7'h05, 8'hA5, 8'hFF)); end
      @(posedge CLK); #1;
      a_we = 1'b0; a_wdata = 8'h00; a_wmask = 8'h00;
      @(negedge CLK);
      total++; if (pins !== rd_pins(7'h05)) begin bad++; $display("FAIL rd_pins got=%h required=%h", pins, rd_pins(7'h05)); end
      total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL rd_early_rvalid got=%b required=0", a_rvalid); end
      @(posedge CLK); #1;
      drive_idle();
      @(negedge CLK);
      total++; if ({a_rvalid, a_rdata} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL raw_rdata got=%b/%h required=1/a5", a_rvalid, a_rdata); end
      @(posedge CLK); #1;
      @(negedge CLK);
      total++; if ({a_rvalid, a_rdata} !== {1'b0, 8'h00}) begin bad++; $display("FAIL rvalid_one_cycle got=%b/%h required=0/00", a_rvalid, a_rdata); end
      model_mem[5] = 8'hA5;
      model_last_b = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_masked_write();
      b_valid = 1'b1; b_we = 1'b1; b_addr = 7'h10; b_wdata = 8'hFF; b_wmask = 8'hFF;
      @(negedge CLK);
      total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL mw_ready got=%b required=1", b_ready); end
      @(posedge CLK); #1;
      b_wdata = 8'h00; b_wmask = 8'h0F;
      @(negedge CLK);
      total++; if (pins !== wr_pins(7'h10, 8'h00, 8'h0F)) begin bad++; $display("FAIL mw_pins got=%h required=%h", pins, wr_pins(7'h10, 8'h00, 8'h0F)); end
      @(posedge CLK); #1;
      b_we = 1'b0; b_wmask = 8'h00;
      @(negedge CLK);
      total++; if (pins !== rd_pins(7'h10)) begin bad++; $display("FAIL mw_rd_pins got=%h required=%h", pins, rd_pins(7'h10)); end
      @(posedge CLK); #1;
      drive_idle();
      @(negedge CLK);
      total++; if ({a_rvalid, b_rvalid, b_rdata} !== {1'b0, 1'b1, 8'hF0}) begin bad++; $display("FAIL mw_readback got=%b%b/%h required=01/f0", a_rvalid, b_rvalid, b_rdata); end
      model_mem[7'h10] = 8'hF0;
      model_last_b = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_contention();
      bit win_a = model_last_b;
      bit prev_a = 1'b0, prev_b = 1'b0;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 7'h05;
      b_valid = 1'b1; b_we = 1'b0; b_addr = 7'h10;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         total++; if ({a_ready, b_ready} !== {win_a, ~win_a}) begin bad++; $display("FAIL cont_grant c=%0d got=%b required=%b", c, {a_ready, b_ready}, {win_a, ~win_a}); end
         total++; if (pins !== rd_pins(win_a ? 7'h05 : 7'h10)) begin bad++; $display("FAIL cont_pins c=%0d got=%h", c, pins); end
         total++; if ({a_rvalid, b_rvalid} !== {prev_a, prev_b}) begin bad++; $display("FAIL cont_rvalid c=%0d got=%b required=%b", c, {a_rvalid, b_rvalid}, {prev_a, prev_b}); end
         total++; if ({a_rdata, b_rdata} !== {(prev_a ? model_mem[5] : 8'h00), (prev_b ? model_mem[7'h10] : 8'h00)}) begin bad++; $display("FAIL cont_rdata c=%0d got=%h/%h", c, a_rdata, b_rdata); end
         prev_a = win_a; prev_b = ~win_a; win_a = ~win_a;
         @(posedge CLK); #1;
      end
      drive_idle();
      @(negedge CLK);
      total++; if ({a_rvalid, b_rvalid} !== {prev_a, prev_b}) begin bad++; $display("FAIL cont_last_rvalid got=%b required=%b", {a_rvalid, b_rvalid}, {prev_a, prev_b}); end
      total++; if (b_rdata !== (prev_b ? model_mem[7'h10] : 8'h00)) begin bad++; $display("FAIL cont_last_rdata got=%h", b_rdata); end
      model_last_b = win_a;
      @(posedge CLK); #1;
   endtask

   task automatic test_idle();
      drive_idle();
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         total++; if (pins !== idle_pins()) begin bad++; $display("FAIL idle_pins c=%0d got=%h required=%h", c, pins, idle_pins()); end
         total++; if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0000) begin bad++; $display("FAIL idle_flags c=%0d got=%b required=0000", c, {a_ready, b_ready, a_rvalid, b_rvalid}); end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset_mid_read();
      a_valid = 1'b1; a_we = 1'b0; a_addr = 7'h05;
      @(negedge CLK);
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rmr_first_ready got=%b required=1", a_ready); end
      @(posedge CLK); #1;
      @(negedge CLK);
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rmr_second_ready got=%b required=1", a_ready); end
      #1 RST = 1'b1;
      #1;
      total++; if ({a_ready, pins} !== {1'b0, idle_pins()}) begin bad++; $display("FAIL rmr_pins got=%b/%h required=0/%h", a_ready, pins, idle_pins()); end
      @(posedge CLK); #1;
      total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_rvalid got=%b required=0", a_rvalid); end
      do_reset();
      total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_no_response got=%b required=0", a_rvalid); end
      a_valid = 1'b1; a_we = 1'b0; a_addr = 7'h05;
      b_valid = 1'b1; b_we = 1'b0; b_addr = 7'h10;
      @(negedge CLK);
      total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL rmr_tie_after_reset got=%b required=10", {a_ready, b_ready}); end
      @(posedge CLK); #1;
      drive_idle();
      @(negedge CLK);
      total++; if ({a_rvalid, a_rdata} !== {1'b1, model_mem[5]}) begin bad++; $display("FAIL rmr_read got=%b/%h required=1/%h", a_rvalid, a_rdata, model_mem[5]); end
      model_last_b = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_clear();
      RST = 1'b1;
      drive_idle();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 7'h7F;
`ifdef GF180_RAM_ARB_CLEAR_EN
      for (int i = 0; i < 128; i++) begin
         @(negedge CLK);
         total++; if ({busy, a_ready, pins} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 7'(i), CLR}) begin bad++; $display("FAIL clear_sweep i=%0d busy=%b ready=%b pins=%h", i, busy, a_ready, pins); end
         @(posedge CLK); #1;
      end
      for (int i = 0; i < 128; i++) model_mem[i] = CLR;
`endif
      @(negedge CLK);
      total++; if ({busy, a_ready} !== 2'b01) begin bad++; $display("FAIL clear_done busy/ready got=%b required=01", {busy, a_ready}); end
      total++; if (pins !== rd_pins(7'h7F)) begin bad++; $display("FAIL clear_rd_pins got=%h required=%h", pins, rd_pins(7'h7F)); end
      @(posedge CLK); #1;
      drive_idle();
      @(negedge CLK);
      total++; if ({a_rvalid, a_rdata} !== {1'b1, model_mem[7'h7F]}) begin bad++; $display("FAIL clear_readback got=%b/%h required=1/%h", a_rvalid, a_rdata, model_mem[7'h7F]); end
      model_last_b = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_random();
      bit a_hold = 1'b0, b_hold = 1'b0, ga, gb, nrv_a, nrv_b;
      bit rv_a = 1'b0, rv_b = 1'b0;
      logic [7:0] rd_a = 8'h00, rd_b = 8'h00, nrd_a, nrd_b;
      logic [24:0] exp_pins;
      for (int c = 0; c < 400; c++) begin
         if (!a_hold) begin
            a_valid = ($urandom_range(0, 9) < 7); a_we = 1'($urandom); a_addr = 7'($urandom_range(0, 15));
            a_wdata = 8'($urandom); a_wmask = 8'($urandom);
         end
         if (!b_hold) begin
            b_valid = ($urandom_range(0, 9) < 7); b_we = 1'($urandom); b_addr = 7'($urandom_range(0, 15));
            b_wdata = 8'($urandom); b_wmask = 8'($urandom);
         end
         // a lone requester wins; on contention the port served less recently wins
         ga = a_valid && (!b_valid || model_last_b);
         gb = b_valid && !ga;
         exp_pins = ga ? (a_we ? wr_pins(a_addr, a_wdata, a_wmask) : rd_pins(a_addr)) :
                    gb ? (b_we ? wr_pins(b_addr, b_wdata, b_wmask) : rd_pins(b_addr)) : idle_pins();
         @(negedge CLK);
         total++; if ({a_ready, b_ready} !== {ga, gb}) begin bad++; $display("FAIL rnd_ready c=%0d got=%b required=%b", c, {a_ready, b_ready}, {ga, gb}); end
         total++; if (pins !== exp_pins) begin bad++; $display("FAIL rnd_pins c=%0d got=%h required=%h", c, pins, exp_pins); end
         total++; if ({a_rvalid, b_rvalid} !== {rv_a, rv_b}) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b required=%b", c, {a_rvalid, b_rvalid}, {rv_a, rv_b}); end
         total++; if ({a_rdata, b_rdata} !== {(rv_a ? rd_a : 8'h00), (rv_b ? rd_b : 8'h00)}) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h required=%h/%h", c, a_rdata, b_rdata, rv_a ? rd_a : 8'h00, rv_b ? rd_b : 8'h00); end
         nrv_a = ga && !a_we; nrd_a = model_mem[a_addr];
         nrv_b = gb && !b_we; nrd_b = model_mem[b_addr];
         if (ga && a_we) model_mem[a_addr] = (model_mem[a_addr] & ~a_wmask) | (a_wdata & a_wmask);
         if (gb && b_we) model_mem[b_addr] = (model_mem[b_addr] & ~b_wmask) | (b_wdata & b_wmask);
         if (ga) model_last_b = 1'b0;
         else if (gb) model_last_b = 1'b1;
         a_hold = a_valid && !ga;
         b_hold = b_valid && !gb;
         @(posedge CLK); #1;
         rv_a = nrv_a; rd_a = nrd_a; rv_b = nrv_b; rd_b = nrd_b;
      end
      drive_idle();
      @(negedge CLK);
      total++; if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== {rv_a, rv_b, (rv_a ? rd_a : 8'h00), (rv_b ? rd_b : 8'h00)}) begin bad++; $display("FAIL rnd_tail got=%b%b/%h/%h", a_rvalid, b_rvalid, a_rdata, b_rdata); end
      @(posedge CLK); #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) model_mem[i] = init_pattern(i);
      drive_idle();
      test_reset();
      test_write_read();
      test_masked_write();
      test_contention();
      test_idle();
      test_reset_mid_read();
      test_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gf180_ram_arbiter.md
Name: gf180_ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of one gf180 128x8 SRAM macro (via its wrapper).
- Two independent requesters (port A, port B) each issue read or bit-masked write transactions over a valid/ready handshake.
- Block drives the macro's active-low CEN/GWEN/WEN pins, address and data, and returns read data with a registered response valid.
- Serves at most one access per clock.

Parameters:
- ADDR_W, 7, SRAM address width (128 words).
- DATA_W, 8, SRAM data width; also the width of the write mask.
- CLEAR_VALUE, 8'h00, word written during the post-reset clear sweep (optional feature only).

Ports:
- CLK  in  1  sole clock; all state on rising edge.
- RST  in  1  synchronous reset, active-high.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  word address.
- a_wdata  in  DATA_W  write data.
- a_wmask  in  DATA_W  per-bit write enable, 1 = write bit.
- a_rvalid  out  1  read data valid on a_rdata.
- a_rdata  out  DATA_W  read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_wmask, b_rvalid, b_rdata  same as port A, for port B.
- busy  out  1  clear sweep in progress.
- ram_cen  out  1  to macro CEN, active-low.
- ram_gwen  out  1  to macro GWEN, active-low (0 = write).
- ram_wen  out  DATA_W  to macro WEN, active-low per bit.
- ram_a  out  ADDR_W  to macro A.
- ram_d  out  DATA_W  to macro D.
- ram_q  in  DATA_W  from macro Q.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset state (while RST=1): ram_cen=1, ram_gwen=1, ram_wen=all 1, ram_a=0, ram_d=0, a_ready=b_ready=0, a_rvalid=b_rvalid=0, busy=0. RR pointer is set to "last=B", so A wins the first tie.
- Arbitration is combinational within the cycle:
  - grant_x = x_valid & ~busy & ~RST & (other port not valid, or pointer favours x).
  - x_ready = grant_x.
  - Transfer occurs when x_valid & x_ready.
  - Pointer updates to the granted port on each transfer; unchanged when idle.
- A valid request that is not granted must stay stable until granted. The arbiter does not register requests.
- RAM pins are combinational from the granted request; the macro captures them on the next CLK edge.
  - Granted read: ram_cen=0, ram_gwen=1, ram_wen=all 1, ram_a=addr, ram_d=0.
  - Granted write: ram_cen=0, ram_gwen=0, ram_wen=~wmask, ram_a=addr, ram_d=wdata.
  - wmask=0 still performs an access cycle with no bits written.
  - No grant: ram_cen=1, ram_gwen=1, ram_wen=all 1, ram_a=0, ram_d=0.
- Read response:
  - x_rvalid is registered: x_rvalid <= grant_x & ~x_we. It asserts exactly 1 cycle after acceptance and lasts 1 cycle.
  - x_rdata = ram_q when x_rvalid=1, else 0.
  - Writes produce no response.
- Throughput: one access per cycle. Back-to-back reads on one port give back-to-back rvalid pulses.
- Fairness: with both ports continuously valid, grants strictly alternate A, B, A, B...
- Read-after-write to the same address on consecutive cycles returns the new data; the macro is write-then-read ordered by cycle.
- RST asserted mid-operation: pending rvalid is cleared on that edge, no response is generated for the in-flight read, and the pointer is reset.

Optional Feature:
- Macro: GF180_RAM_ARB_CLEAR_EN.
- Defined:
  - On the first cycle after RST deasserts, a 7-bit sweep counter starts at 0 and busy=1.
  - Each cycle drives ram_cen=0, ram_gwen=0, ram_wen=0, ram_a=counter, ram_d=CLEAR_VALUE.
  - Counter increments to 127; busy drops after the write to address 127, so busy is high for exactly 128 cycles.
  - a_ready and b_ready are held 0 while busy.
  - RST during the sweep restarts it at address 0 after release.
- Undefined: no counter, busy tied 0, requests are served from the first cycle after RST deasserts.

Test Plan:
- Write then read: A writes addr 0x05 data 0xA5 mask 0xFF; next cycle A reads 0x05 -> ram_gwen=0 then 1, a_rvalid one cycle after read grant, a_rdata=0xA5.
- Masked write: prior 0xFF at 0x10; B writes 0x00 mask 0x0F -> ram_wen=0xF0; readback 0xF0.
- Contention: A and B both continuously valid with reads for 6 cycles -> grants A,B,A,B,A,B; each rvalid pulse 1 cycle after its own grant; the other port's rvalid stays 0.
- Idle: no valid -> ram_cen=1 every cycle, both rvalid 0.
- Reset mid-read: A read granted, RST=1 next edge -> a_rvalid stays 0, ram_cen=1, the next tie after release goes to A.
- With GF180_RAM_ARB_CLEAR_EN: release RST -> busy high exactly 128 cycles, ram_a sweeps 0..127, ready held 0; then a read of addr 0x7F returns 0x00.
